// File: rtl/sift_pkg.sv
// sift_pkg: constants and helpers shared by the SIFT front-end blocks.
//   DEF_PIX_W / DEF_COLS / DEF_ROWS : default lane width and frame geometry
//   lane_w()                        : width of one difference-of-Gaussian lane
package sift_pkg;

  localparam int DEF_PIX_W = 8;
  localparam int DEF_COLS  = 640;
  localparam int DEF_ROWS  = 480;

  // A plain difference of two zero-extended PIX_W lanes needs PIX_W+1 bits.
  // When saturation is enabled the lane is narrowed to out_w.
  function automatic int lane_w(input int pix_w, input int out_w, input bit sat_en);
    return sat_en ? out_w : pix_w + 1;
  endfunction

endpackage

// File: rtl/dog_diff_stream_sat_clamp.sv
// sat_clamp: signed width converter for one difference lane.
//   din  [IN_W-1:0]  signed input
//   dout [OUT_W-1:0] signed output; clamped to the OUT_W range when narrower,
//                    sign-extended when wider, passed through when equal.
module sat_clamp #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  if (OUT_W == IN_W) begin : g_pass
    assign dout = din;
  end else if (OUT_W > IN_W) begin : g_ext
    assign dout = {{(OUT_W-IN_W){din[IN_W-1]}}, din};
  end else begin : g_clamp
    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    always_comb begin
      if (din > MAX_V)      dout = MAX_V[OUT_W-1:0];
      else if (din < MIN_V) dout = MIN_V[OUT_W-1:0];
      else                  dout = din[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/dog_diff_stream.sv
// dog_diff_stream: difference-of-Gaussian lane subtractor for a pixel stream.
// Each input beat carries NUM_SCALES blurred lanes of one pixel; each output
// beat carries NUM_SCALES-1 signed differences (lane k+1 - lane k) tagged
// with the pixel's column/row and end-of-line/frame flags.
//
// Build option: define DOG_SAT_EN to clamp every difference lane to OUT_W
// signed bits; otherwise lanes are emitted at full PIX_W+1 width.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake
//   in_sof                start of frame, sampled on accepted beats
//   in_data               NUM_SCALES packed unsigned PIX_W lanes
//   out_valid/out_ready   output handshake
//   out_data              NUM_SCALES-1 packed signed D-bit lanes
//   out_col, out_row      pixel position of the output beat
//   out_eol, out_eof      last column / last pixel of frame
//   out_err               in_sof arrived while the position was not (0,0)
module dog_diff_stream
  import sift_pkg::*;
#(
  parameter int PIX_W      = DEF_PIX_W,
  parameter int NUM_SCALES = 4,
  parameter int COLS       = DEF_COLS,
  parameter int ROWS       = DEF_ROWS,
  parameter int OUT_W      = 8,
`ifdef DOG_SAT_EN
  localparam int D         = lane_w(PIX_W, OUT_W, 1'b1),
`else
  localparam int D         = lane_w(PIX_W, OUT_W, 1'b0),
`endif
  localparam int DW1       = PIX_W + 1,
  localparam int COL_W     = $clog2(COLS),
  localparam int ROW_W     = $clog2(ROWS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sof,
  input  logic [NUM_SCALES*PIX_W-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(NUM_SCALES-1)*D-1:0]   out_data,
  output logic [COL_W-1:0]              out_col,
  output logic [ROW_W-1:0]              out_row,
  output logic                          out_eol,
  output logic                          out_eof,
  output logic                          out_err
);

  localparam int NL = NUM_SCALES - 1;

  // One enable for the whole pipeline: it moves only when stage 2 can drain.
  logic en;
  logic accept;

  logic [COL_W-1:0] cnt_col, tag_col, nxt_col;
  logic [ROW_W-1:0] cnt_row, tag_row, nxt_row;
  logic             tag_err;

  logic [NL*DW1-1:0] diff;
  logic [NL*D-1:0]   fmt;

  logic              s1_valid;
  logic [NL*DW1-1:0] s1_diff;
  logic [COL_W-1:0]  s1_col;
  logic [ROW_W-1:0]  s1_row;
  logic              s1_err;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // An sof beat is forced to (0,0) and flags an error if the running
  // position disagreed; the counters then continue from the forced tag.
  always_comb begin
    tag_col = cnt_col;
    tag_row = cnt_row;
    tag_err = 1'b0;
    if (in_sof) begin
      tag_col = '0;
      tag_row = '0;
      tag_err = (cnt_col != '0) || (cnt_row != '0);
    end
    nxt_col = tag_col + 1'b1;
    nxt_row = tag_row;
    if (tag_col == COL_W'(COLS-1)) begin
      nxt_col = '0;
      nxt_row = (tag_row == ROW_W'(ROWS-1)) ? '0 : tag_row + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_col <= '0;
      cnt_row <= '0;
    end else if (accept) begin
      cnt_col <= nxt_col;
      cnt_row <= nxt_row;
    end
  end

  // Zero-extended operands cannot overflow a PIX_W+1 signed result.
  for (genvar k = 0; k < NL; k++) begin : g_lane
    logic [DW1-1:0] lo_ext, hi_ext;
    assign lo_ext = {1'b0, in_data[k*PIX_W +: PIX_W]};
    assign hi_ext = {1'b0, in_data[(k+1)*PIX_W +: PIX_W]};
    assign diff[k*DW1 +: DW1] = hi_ext - lo_ext;

    sat_clamp #(
      .IN_W  (DW1),
      .OUT_W (D)
    ) u_sat (
      .din  (s1_diff[k*DW1 +: DW1]),
      .dout (fmt[k*D +: D])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
      s1_col   <= '0;
      s1_row   <= '0;
      s1_err   <= 1'b0;
    end else if (en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_diff <= diff;
        s1_col  <= tag_col;
        s1_row  <= tag_row;
        s1_err  <= tag_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_col   <= '0;
      out_row   <= '0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      out_err   <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= fmt;
        out_col  <= s1_col;
        out_row  <= s1_row;
        out_eol  <= (s1_col == COL_W'(COLS-1));
        out_eof  <= (s1_col == COL_W'(COLS-1)) && (s1_row == ROW_W'(ROWS-1));
        out_err  <= s1_err;
      end
    end
  end

endmodule

// File: tb/tb_dog_diff_stream.sv
// Bench for dog_diff_stream: random pixel stream scored against a queue
// model of the expected output beats. Frame height is reduced so a full
// frame (and the wrap to the next one) fits in a short run.
module tb_dog_diff_stream;

  localparam int PIX_W  = 8;
  localparam int NS     = 4;
  localparam int COLS   = 640;
  localparam int ROWS   = 6;
  localparam int OUT_W  = 8;
`ifdef DOG_SAT_EN
  localparam int D      = OUT_W;
`else
  localparam int D      = PIX_W + 1;
`endif
  localparam int IN_DW  = NS * PIX_W;
  localparam int OUT_DW = (NS - 1) * D;
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_sof;
  logic [IN_DW-1:0]  in_data;
  logic              out_valid, out_ready;
  logic [OUT_DW-1:0] out_data;
  logic [COL_W-1:0]  out_col;
  logic [ROW_W-1:0]  out_row;
  logic              out_eol, out_eof, out_err;

  dog_diff_stream #(
    .PIX_W      (PIX_W),
    .NUM_SCALES (NS),
    .COLS       (COLS),
    .ROWS       (ROWS),
    .OUT_W      (OUT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_row   (out_row),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_DW-1:0] data;
    int                col;
    int                row;
    logic              eol;
    logic              eof;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  int   m_col, m_row;
  int   n_checks, n_pass;
  int   n_eof, n_err;
  bit   rdy_rand;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Position and difference rules straight from the pixel-stream definition.
  function automatic void model_accept(input logic [IN_DW-1:0] d, input logic sof);
    exp_t e;
    int   lo, hi, df;
    e.err = 1'b0;
    if (sof) begin
      e.err = (m_col != 0) || (m_row != 0);
      m_col = 0;
      m_row = 0;
    end
    e.col = m_col;
    e.row = m_row;
    e.eol = (m_col == COLS - 1);
    e.eof = e.eol && (m_row == ROWS - 1);
    e.data = '0;
    for (int k = 0; k < NS - 1; k++) begin
      lo = int'(d[k*PIX_W +: PIX_W]);
      hi = int'(d[(k+1)*PIX_W +: PIX_W]);
      df = hi - lo;
`ifdef DOG_SAT_EN
      if (df > (1 << (OUT_W-1)) - 1) df = (1 << (OUT_W-1)) - 1;
      if (df < -(1 << (OUT_W-1)))    df = -(1 << (OUT_W-1));
`endif
      e.data[k*D +: D] = df[D-1:0];
    end
    exp_q.push_back(e);
    m_col++;
    if (m_col == COLS) begin
      m_col = 0;
      m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
    end
  endfunction

  // Handshakes are decided by values settled since the previous rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_beat", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check_eq("data", 64'(out_data), 64'(e.data));
          check_eq("col",  64'(out_col),  64'(e.col));
          check_eq("row",  64'(out_row),  64'(e.row));
          check_eq("eol",  64'(out_eol),  64'(e.eol));
          check_eq("eof",  64'(out_eof),  64'(e.eof));
          check_eq("err",  64'(out_err),  64'(e.err));
          if (out_eof) n_eof++;
          if (out_err) n_err++;
        end
      end
      if (in_valid && in_ready) model_accept(in_data, in_sof);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 9) < 8);
  endtask

  task automatic drive_beat(input logic [IN_DW-1:0] d, input logic sof);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check_eq("accept_tmo", 64'(in_ready), 64'(1));
        break;
      end
      tick();
    end
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int n = 0;
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    @(negedge clk);
    check_eq("drain", 64'(exp_q.size()), 64'(0));
    tick();
  endtask

  task automatic stall_test();
    rdy_rand  = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tick();
    tick();
    in_valid = 1'b1;
    in_data  = IN_DW'($urandom());
    in_sof   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("stall_in_ready",  64'(in_ready),  64'(0));
      check_eq("stall_out_valid", 64'(out_valid), 64'(1));
      tick();
    end
    in_valid = 1'b0;
    rdy_rand = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    rdy_rand  = 1'b0;
    m_col = 0; m_row = 0;
    n_checks = 0; n_pass = 0; n_eof = 0; n_err = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_out_data",  64'(out_data),  64'(0));
    check_eq("rst_col_row",   64'({out_col, out_row}), 64'(0));
    check_eq("rst_flags",     64'({out_eol, out_eof, out_err}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'(1));
    tick();

    // Two-cycle latency on an idle pipeline.
    drive_beat({8'd8, 8'd7, 8'd6, 8'd5}, 1'b1);
    @(negedge clk);
    check_eq("lat_cycle1", 64'(out_valid), 64'(0));
    tick();
    @(negedge clk);
    check_eq("lat_cycle2", 64'(out_valid), 64'(1));
    tick();

    // Small and extreme lane patterns, back to back.
    drive_beat({8'd3, 8'd4, 8'd5, 8'd6}, 1'b0);
    drive_beat({8'd255, 8'd0, 8'd255, 8'd0}, 1'b0);
    drive_beat({8'd0, 8'd255, 8'd0, 8'd255}, 1'b0);
    drive_beat({8'd128, 8'd127, 8'd1, 8'd0}, 1'b0);
    drain();

    // Random frame with bubbles, random back-pressure and a held stall.
    rdy_rand = 1'b1;
    drive_beat(IN_DW'($urandom()), 1'b1);
    for (int i = 1; i < COLS * ROWS; i++) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      drive_beat(IN_DW'($urandom()), 1'b0);
      if (i == 100) stall_test();
    end
    drive_beat(IN_DW'($urandom()), 1'b1);
    for (int i = 1; i < 2 * COLS + 17; i++)
      drive_beat(IN_DW'($urandom()), 1'b0);
    drive_beat(IN_DW'($urandom()), 1'b1);
    repeat (5) drive_beat(IN_DW'($urandom()), 1'b0);
    drain();

    check_eq("eof_count", 64'(n_eof), 64'(1));
    check_eq("err_count", 64'(n_err), 64'(2));

    // Reset with two beats in flight.
    rdy_rand  = 1'b0;
    out_ready = 1'b0;
    drive_beat(IN_DW'($urandom()), 1'b0);
    drive_beat(IN_DW'($urandom()), 1'b0);
    rst = 1'b1;
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    @(negedge clk);
    check_eq("rst_flush_valid", 64'(out_valid), 64'(0));
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("rst_flush_ready", 64'(in_ready), 64'(1));
    tick();
    drive_beat(IN_DW'($urandom()), 1'b0);
    drive_beat(IN_DW'($urandom()), 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
